// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcodes, width defaults, FSM states.
package alu_pkg;

    localparam int unsigned ALU_DATA_WIDTH = 32;
    localparam int unsigned ALU_OP_WIDTH   = 4;

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = 4'b0000;
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = 4'b0001;
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLLI = 4'b0010;
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRLI = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant; rr_ptr only breaks ties.
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_ptr,
    output logic grant,
    output logic any_valid
);

    always_comb begin
        any_valid = valid0 | valid1;
        grant     = (valid0 && valid1) ? rr_ptr : valid1;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters,
// one operation in flight at a time, round-robin on contention.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int unsigned OP_WIDTH   = ALU_OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [OP_WIDTH-1:0]   req0_op_i,
    input  logic [DATA_WIDTH-1:0] req0_a_i,
    input  logic [DATA_WIDTH-1:0] req0_b_i,
    output logic                  rsp0_valid_o,
    input  logic                  rsp0_ready_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [OP_WIDTH-1:0]   req1_op_i,
    input  logic [DATA_WIDTH-1:0] req1_a_i,
    input  logic [DATA_WIDTH-1:0] req1_b_i,
    output logic                  rsp1_valid_o,
    input  logic                  rsp1_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_result_o,
    output logic                  rsp_zero_o,
    output logic [OP_WIDTH-1:0]   alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  alu_zero_i
);

    state_t                state_q;
    state_t                state_d;
    logic                  rr_ptr_q;
    logic                  grant_q;
    logic                  arb_grant;
    logic                  arb_any;
    logic                  capture;
    logic                  rsp_fire;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;

    rr_arbiter2 u_rr_arbiter2 (
        .valid0    (req0_valid_i),
        .valid1    (req1_valid_i),
        .rr_ptr    (rr_ptr_q),
        .grant     (arb_grant),
        .any_valid (arb_any)
    );

    // Next state plus handshake decode; ready is gated by reset so it reads 0 while held.
    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        rsp_fire     = 1'b0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any && !reset) begin
                    capture      = 1'b1;
                    req0_ready_o = ~arb_grant;
                    req1_ready_o = arb_grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid_o = ~grant_q;
                rsp1_valid_o = grant_q;
                rsp_fire     = grant_q ? rsp1_ready_i : rsp0_ready_i;
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, result capture and round-robin pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q     <= 1'b0;
            grant_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
        end else begin
            if (capture) begin
                grant_q <= arb_grant;
                op_q    <= arb_grant ? req1_op_i : req0_op_i;
                a_q     <= arb_grant ? req1_a_i  : req0_a_i;
                b_q     <= arb_grant ? req1_b_i  : req0_b_i;
            end
            if (state_q == EXEC) begin
                rsp_result_o <= alu_result_i;
                rsp_zero_o   <= alu_zero_i;
            end
            if (rsp_fire) begin
                rr_ptr_q <= ~grant_q;
            end
        end
    end

    assign alu_op_o = op_q;
    assign alu_a_o  = a_q;
    assign alu_b_o  = b_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, e.g. the core datapath and a debug/address-generation unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Grants alternate round-robin; operands are captured, the ALU is driven from registers, and the result and zero flag are returned registered.
- Sits between the requesters and the ALU instance; the ALU itself is external.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- OP_WIDTH, 4, ALU operation code width (0000 ADD, 0001 OR, 0010 SLLI, 0011 SRLI).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid_i  input  1  requester 0 has an operation.
- req0_ready_o  output  1  requester 0 operation accepted this cycle.
- req0_op_i  input  OP_WIDTH  requester 0 opcode.
- req0_a_i  input  DATA_WIDTH  requester 0 operand A.
- req0_b_i  input  DATA_WIDTH  requester 0 operand B.
- rsp0_valid_o  output  1  result valid for requester 0.
- rsp0_ready_i  input  1  requester 0 consumes the result.
- req1_valid_i, req1_ready_o, req1_op_i, req1_a_i, req1_b_i, rsp1_valid_o, rsp1_ready_i: same as requester 0.
- rsp_result_o  output  DATA_WIDTH  registered ALU result, shared by both requesters.
- rsp_zero_o  output  1  registered ALU zero flag.
- alu_op_o  output  OP_WIDTH  to ALU_Operation_i.
- alu_a_o  output  DATA_WIDTH  to ALU A_i.
- alu_b_o  output  DATA_WIDTH  to ALU B_i.
- alu_result_i  input  DATA_WIDTH  from ALU_Result_o.
- alu_zero_i  input  1  from ALU Zero_o.

Behaviour:
- Reset values (asynchronous): state=IDLE, rr_ptr=0, grant=0, op/a/b registers=0, rsp_result_o=0, rsp_zero_o=0, all ready/valid outputs=0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - If only reqN_valid_i is high, grant N.
  - If both are high, grant rr_ptr.
  - In the same cycle, reqN_ready_o=1 combinationally, so the handshake completes that cycle.
  - Capture op/a/b into registers, record grant, go to EXEC.
  - If neither is valid, stay in IDLE.
- ready outputs: reqN_ready_o is high only in IDLE and only for the granted requester. It is never high in EXEC or RESP.
- EXEC (one cycle):
  - alu_*_o are driven from the captured registers.
  - At the clock edge, rsp_result_o<=alu_result_i and rsp_zero_o<=alu_zero_i; go to RESP.
- alu_*_o outside EXEC hold the last captured values.
- RESP:
  - rspN_valid_o=1 for the granted requester only.
  - rsp_result_o and rsp_zero_o stay stable until rspN_ready_i=1.
  - On that handshake: rr_ptr<=~grant, go to IDLE.
- Latency: request accepted at edge T; result registered at T+1; rsp valid from T+1 through at least T+2; minimum 3 cycles per operation; no pipelining, so only one operation is outstanding.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1; neither requester waits more than one operation.
- Input changes:
  - Request inputs that change after acceptance do not affect the operation in flight.
  - A de-asserted valid in IDLE is not latched.
- Response back-pressure: RESP holds indefinitely while ready=0, and the other requester stalls.
- rspN_ready_i while rspN_valid_o=0 is ignored.
- Reset mid-operation aborts the operation: no response is issued and the FSM returns to IDLE with rr_ptr=0.
- Unknown opcodes pass through unchanged; the ALU returns 0 and zero=1.

Decomposition:
- Shared package (alu_pkg) holds:
  - ALU opcode localparams ADD/OR/SLLI/SRLI.
  - The OP_WIDTH and DATA_WIDTH defaults.
  - The state encodings IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One sub-module: rr_arbiter2. It is a combinational 2-way round-robin grant from (valid0, valid1, rr_ptr) producing grant and any_valid.
- The top module holds the FSM and the operand/result registers.

Test Plan:
- Reset then idle: assert reset mid-run -> all outputs 0 immediately; after release, no ready/valid with no requests.
- Single request: req0 ADD a=5, b=7 -> req0_ready_o at T; rsp0_valid_o from T+2 (first cycle after the T+1 edge) with rsp_result_o=12, rsp_zero_o=0. With rsp0_ready_i=1, the FSM is back in IDLE at T+3.
- Contention: both valid continuously; req0 OR 0xF0|0x0F, req1 SRLI 0x80>>3 -> grant order 0,1,0,1; results 0xFF and 0x10; rsp1_valid_o never coincides with rsp0_valid_o.
- Back-pressure: req1 SLLI 1<<4, rsp1_ready_i=0 for 5 cycles -> rsp1_valid_o held, rsp_result_o=16 stable, req0_ready_o stays 0; released on handshake.
- Zero flag and operand isolation: req0 ADD 0xFFFFFFFF+1 and change req0_a_i after acceptance -> rsp_result_o=0, rsp_zero_o=1.
- Unknown opcode and reset abort: opcode 4'b1111 -> rsp_result_o=0, rsp_zero_o=1; reset asserted during EXEC -> no rsp valid, rr_ptr=0.
